// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg -- shared widths, types and FSM encodings for the KV10
// write-through cache (wt_cache) and its line storage (wt_cache_ram).
//
// Contents:
//   WORD_W / PADDR_W   machine word and physical word-address widths
//   word_t / paddr_t   convenience typedefs for those widths
//   state_t            cache controller states
//   resp_t             which completion pulse the RESP state emits
//   line_index()       index field of a physical address
//   line_tag()         tag field of a physical address
package wt_cache_pkg;

  localparam int WORD_W  = 36;
  localparam int PADDR_W = 22;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [PADDR_W-1:0] paddr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_MEMWR  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_READ  = 2'd1,
    RESP_WRITE = 2'd2,
    RESP_NXM   = 2'd3
  } resp_t;

  // Index is the low bits of the word address; the tag is everything above.
  function automatic logic [15:0] line_index(input paddr_t addr, input int index_bits);
    logic [15:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < index_bits) idx[i] = addr[i];
    end
    return idx;
  endfunction

  function automatic paddr_t line_tag(input paddr_t addr, input int index_bits);
    return addr >> index_bits;
  endfunction

endpackage

// File: rtl/wt_cache_ram.sv
// wt_cache_ram -- tag + data storage for wt_cache.
// One entry per line, addressed by the line index. One synchronous read
// port and one write port, written in a form that maps onto block RAM or
// a register file. No reset: line validity lives in the parent, so the
// contents here are only meaningful for lines the parent marks valid.
//
// Ports:
//   clk      in   clock, rising edge
//   rd_en    in   capture entry rd_idx into the read register
//   rd_idx   in   read index
//   rd_tag   out  tag of the last captured entry
//   rd_data  out  data word of the last captured entry
//   wr_en    in   write {wr_tag, wr_data} into entry wr_idx
//   wr_idx   in   write index
//   wr_tag   in   tag to store
//   wr_data  in   data word to store
module wt_cache_ram #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 16,
  parameter int WORD_W     = 36
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);

  localparam int LINES   = 1 << INDEX_BITS;
  localparam int ENTRY_W = TAG_W + WORD_W;

  logic [ENTRY_W-1:0] lines [LINES];
  logic [ENTRY_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) lines[wr_idx] <= {wr_tag, wr_data};
    if (rd_en) rd_q <= lines[rd_idx];
  end

  assign rd_tag  = rd_q[ENTRY_W-1:WORD_W];
  assign rd_data = rd_q[WORD_W-1:0];

endmodule

// File: rtl/wt_cache.sv
// wt_cache -- direct-mapped, write-through, one-word-per-line cache that
// sits between the KV10 pager (pag_*) and main memory (mem_*). Read hits
// are answered from local storage one cycle after the request; read misses
// and every write go to memory. Writes allocate the line on success.
// Both sides use a request-level-held-until-ack handshake.
//
// Optional feature: define WT_CACHE_STATS_EN to add hit_count/miss_count
// (36-bit wrapping counters, cleared by reset). Writes are not counted.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   pag_addr, pag_write_data   pager request address / write data
//   pag_read, pag_write        pager request levels (write wins if both)
//   pag_read_data              read data, valid while pag_read_ack is high
//   pag_read_ack, pag_write_ack, pag_nxm   one-cycle completion pulses
//   mem_addr, mem_write_data   memory request address / write data
//   mem_read, mem_write        memory request levels (never both high)
//   mem_read_data              memory read data
//   mem_read_ack, mem_write_ack, mem_nxm   memory completion pulses
//   hit_count, miss_count      (WT_CACHE_STATS_EN only) lookup statistics
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a pager request; read starts the storage read
// ST_LOOKUP | storage output valid; hit acks now, miss goes to memory
// ST_MEMRD  | mem_read held until mem_read_ack (fill) or mem_nxm
// ST_MEMWR  | mem_write held until mem_write_ack (allocate) or mem_nxm
// ST_RESP   | one-cycle read ack / write ack / nxm pulse to the pager
module wt_cache
  import wt_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PADDR_W-1:0] pag_addr,
  input  logic [WORD_W-1:0]  pag_write_data,
  input  logic               pag_read,
  input  logic               pag_write,
  output logic [WORD_W-1:0]  pag_read_data,
  output logic               pag_read_ack,
  output logic               pag_write_ack,
  output logic               pag_nxm,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [WORD_W-1:0]  mem_read_data,
  input  logic               mem_read_ack,
  input  logic               mem_write_ack,
  input  logic               mem_nxm
`ifdef WT_CACHE_STATS_EN
  ,
  output logic [WORD_W-1:0]  hit_count,
  output logic [WORD_W-1:0]  miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = PADDR_W - INDEX_BITS;

  state_t              state;
  resp_t               resp_q;
  paddr_t              addr_q;
  word_t               wdata_q;
  word_t               rdata_q;
  logic [LINES-1:0]    valid;

  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_W-1:0]      tag_q;

  logic                  ram_rd_en;
  logic [INDEX_BITS-1:0] ram_rd_idx;
  logic [TAG_W-1:0]      ram_rd_tag;
  word_t                 ram_rd_data;
  logic                  ram_wr_en;
  word_t                 ram_wr_data;

  logic lookup_hit;
  logic lookup_miss;

  assign idx_q = addr_q[INDEX_BITS-1:0];
  assign tag_q = addr_q[PADDR_W-1:INDEX_BITS];

  // The storage read is launched on the IDLE edge that accepts a read, so
  // its output is ready during LOOKUP. A simultaneous write takes priority.
  assign ram_rd_en  = (state == ST_IDLE) && pag_read && !pag_write;
  assign ram_rd_idx = pag_addr[INDEX_BITS-1:0];

  // Line update lands on the memory ack edge so a following read hits.
  assign ram_wr_en   = ((state == ST_MEMRD) && mem_read_ack) ||
                       ((state == ST_MEMWR) && mem_write_ack);
  assign ram_wr_data = (state == ST_MEMRD) ? mem_read_data : wdata_q;

  wt_cache_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .WORD_W     (WORD_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_idx  (ram_rd_idx),
    .rd_tag  (ram_rd_tag),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_idx  (idx_q),
    .wr_tag  (tag_q),
    .wr_data (ram_wr_data)
  );

  assign lookup_hit  = (state == ST_LOOKUP) && valid[idx_q] && (ram_rd_tag == tag_q);
  assign lookup_miss = (state == ST_LOOKUP) && !lookup_hit;

  // Hit data comes straight from the storage register so the hit ack can
  // appear in the LOOKUP cycle; fill data is held in rdata_q for RESP.
  assign pag_read_data = lookup_hit ? ram_rd_data : rdata_q;
  assign pag_read_ack  = lookup_hit || (resp_q == RESP_READ);
  assign pag_write_ack = (resp_q == RESP_WRITE);
  assign pag_nxm       = (resp_q == RESP_NXM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      resp_q         <= RESP_NONE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      valid          <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_q <= RESP_NONE;
          if (pag_write) begin
            addr_q         <= pag_addr;
            wdata_q        <= pag_write_data;
            mem_addr       <= pag_addr;
            mem_write_data <= pag_write_data;
            mem_write      <= 1'b1;
            state          <= ST_MEMWR;
          end else if (pag_read) begin
            addr_q <= pag_addr;
            state  <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (lookup_hit) begin
            state <= ST_IDLE;
          end else begin
            mem_addr <= addr_q;
            mem_read <= 1'b1;
            state    <= ST_MEMRD;
          end
        end

        ST_MEMRD: begin
          if (mem_read_ack) begin
            valid[idx_q] <= 1'b1;
            rdata_q      <= mem_read_data;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            resp_q       <= RESP_READ;
            state        <= ST_RESP;
          end else if (mem_nxm) begin
            mem_read <= 1'b0;
            mem_addr <= '0;
            resp_q   <= RESP_NXM;
            state    <= ST_RESP;
          end
        end

        ST_MEMWR: begin
          if (mem_write_ack) begin
            valid[idx_q]   <= 1'b1;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            resp_q         <= RESP_WRITE;
            state          <= ST_RESP;
          end else if (mem_nxm) begin
            // The old line may hold a stale copy of this word; drop it.
            valid[idx_q]   <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            resp_q         <= RESP_NXM;
            state          <= ST_RESP;
          end
        end

        ST_RESP: begin
          resp_q  <= RESP_NONE;
          rdata_q <= '0;
          state   <= ST_IDLE;
        end

        default: begin
          resp_q    <= RESP_NONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WT_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit)  hit_count  <= hit_count + 1'b1;
      if (lookup_miss) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wt_cache.sv
// tb_wt_cache -- self-checking bench for wt_cache with a behavioural memory
// responder and a scoreboard of expected pager responses.
module tb_wt_cache;

  logic        clk;
  logic        reset;
  logic [21:0] pag_addr;
  logic [35:0] pag_write_data;
  logic        pag_read;
  logic        pag_write;
  logic [35:0] pag_read_data;
  logic        pag_read_ack;
  logic        pag_write_ack;
  logic        pag_nxm;
  logic [21:0] mem_addr;
  logic [35:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [35:0] mem_read_data;
  logic        mem_read_ack;
  logic        mem_write_ack;
  logic        mem_nxm;
`ifdef WT_CACHE_STATS_EN
  logic [35:0] hit_count;
  logic [35:0] miss_count;
`endif

  wt_cache dut (
    .clk            (clk),
    .reset          (reset),
    .pag_addr       (pag_addr),
    .pag_write_data (pag_write_data),
    .pag_read       (pag_read),
    .pag_write      (pag_write),
    .pag_read_data  (pag_read_data),
    .pag_read_ack   (pag_read_ack),
    .pag_write_ack  (pag_write_ack),
    .pag_nxm        (pag_nxm),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .mem_read_ack   (mem_read_ack),
    .mem_write_ack  (mem_write_ack),
    .mem_nxm        (mem_nxm)
`ifdef WT_CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [21:0] NXM_BASE = 22'o10000000;
  localparam int K_READ = 1, K_WRITE = 2, K_NXM = 3;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model / responder ----------------
  logic [35:0] mem_model [logic [21:0]];
  int          mem_lat = 2;
  bit          mem_enable = 1'b1;
  logic [35:0] last_wdata = '0;

  function automatic logic [35:0] mem_value(input logic [21:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {14'h1a5, a};
  endfunction

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_read_ack  = 1'b0;
    mem_write_ack = 1'b0;
    mem_nxm       = 1'b0;
    mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_enable) begin
        mem_read_ack  = 1'b0;
        mem_write_ack = 1'b0;
        mem_nxm       = 1'b0;
        if (mem_read || mem_write) begin
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            wait_cnt = 0;
            if (mem_addr >= NXM_BASE) begin
              mem_nxm = 1'b1;
            end else if (mem_read) begin
              mem_read_data = mem_value(mem_addr);
              mem_read_ack  = 1'b1;
            end else begin
              mem_model[mem_addr] = mem_write_data;
              last_wdata    = mem_write_data;
              mem_write_ack = 1'b1;
            end
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  int   mem_rd_starts = 0;
  int   rd_ack_cnt    = 0;
  int   nxm_cnt       = 0;
  int   both_cnt      = 0;
  logic mr_prev       = 1'b0;

  always @(posedge clk) begin
    mr_prev <= mem_read;
    if (mem_read && !mr_prev) mem_rd_starts <= mem_rd_starts + 1;
    if (pag_read_ack)         rd_ack_cnt    <= rd_ack_cnt + 1;
    if (pag_nxm)              nxm_cnt       <= nxm_cnt + 1;
    if (mem_read && mem_write) both_cnt     <= both_cnt + 1;
  end

  // ---------------- scoreboard + pager driver ----------------
  typedef struct {
    int          kind;
    logic [35:0] data;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  // Drives one request, waits (bounded) for its completion, pops the
  // expected response and compares kind, data and latency in cycles.
  task automatic pag_req(input string tag, input bit wr, input logic [21:0] a,
                         input logic [35:0] wd, input int exp_kind,
                         input logic [35:0] exp_data, input int exp_lat);
    exp_t        e;
    int          cyc;
    int          kind;
    logic [35:0] got;
    e.kind = exp_kind;
    e.data = exp_data;
    e.lat  = exp_lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    pag_addr       = a;
    pag_write_data = wd;
    pag_write      = wr;
    pag_read       = !wr;
    cyc  = 0;
    kind = 0;
    got  = '0;
    while (kind == 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (pag_read_ack) begin
        kind = K_READ;
        got  = pag_read_data;
      end else if (pag_write_ack) kind = K_WRITE;
      else if (pag_nxm)           kind = K_NXM;
    end
    pag_read  = 1'b0;
    pag_write = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_kind"}, kind, e.kind);
    if (e.kind == K_READ) check({tag, "_data"}, got, e.data);
    if (e.lat > 0)        check({tag, "_lat"}, cyc, e.lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic        ref_valid [64];
  logic [15:0] ref_tag   [64];

  initial begin
    int          s;
    int          hc;
    logic [21:0] a;
    logic [35:0] d;
    bit          wr;
    int          i6;
    bit          hit;
    bit          found;

    reset          = 1'b1;
    pag_addr       = '0;
    pag_write_data = '0;
    pag_read       = 1'b0;
    pag_write      = 1'b0;
    mem_model[22'o1000] = 36'o123456701234;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_ack", pag_read_ack, 0);
    check("rst_wr_ack", pag_write_ack, 0);
    check("rst_nxm",    pag_nxm, 0);
    check("rst_mem_rd", mem_read, 0);
    check("rst_mem_wr", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata",  pag_read_data, 0);
    reset = 1'b0;

    // Cold read miss, then hit.
    s = mem_rd_starts;
    pag_req("miss1", 1'b0, 22'o1000, '0, K_READ, 36'o123456701234, 2 + mem_lat);
    check("miss1_memrd", mem_rd_starts - s, 1);
    s = mem_rd_starts;
    pag_req("hit1", 1'b0, 22'o1000, '0, K_READ, 36'o123456701234, 1);
    check("hit1_memrd", mem_rd_starts - s, 0);

    // Write-through then hit with the new data.
    pag_req("wr1", 1'b1, 22'o1000, 36'o777, K_WRITE, '0, 1 + mem_lat);
    check("wr1_memdata", last_wdata, 36'o777);
    s = mem_rd_starts;
    pag_req("hit2", 1'b0, 22'o1000, '0, K_READ, 36'o777, 1);
    check("hit2_memrd", mem_rd_starts - s, 0);

    // Alias on index 0: both miss, original misses again (slower memory).
    mem_lat = 5;
    s = mem_rd_starts;
    pag_req("alias_b", 1'b0, 22'o1100, '0, K_READ, mem_value(22'o1100), 2 + 5);
    pag_req("alias_a", 1'b0, 22'o1000, '0, K_READ, 36'o777, 2 + 5);
    check("alias_memrd", mem_rd_starts - s, 2);
    mem_lat = 2;

    // Nonexistent memory: one nxm pulse, no fill.
    s  = rd_ack_cnt;
    hc = nxm_cnt;
    pag_req("nxm1", 1'b0, 22'o17000000, '0, K_NXM, '0, 2 + mem_lat);
    check("nxm1_pulses", nxm_cnt - hc, 1);
    check("nxm1_rdack",  rd_ack_cnt - s, 0);
    s = mem_rd_starts;
    pag_req("nxm2", 1'b0, 22'o17000000, '0, K_NXM, '0, 2 + mem_lat);
    check("nxm2_memrd", mem_rd_starts - s, 1);

    // Reset in the middle of a memory read, then a stale memory ack.
    mem_enable = 1'b0;
    @(posedge clk); #1;
    pag_addr = 22'o3000;
    pag_read = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_read) found = 1'b1;
    end
    check("rstmid_memrd_seen", found, 1);
    reset    = 1'b1;
    pag_read = 1'b0;
    s = rd_ack_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_memrd_low", mem_read, 0);
    repeat (2) @(posedge clk);
    #1;
    mem_read_data = 36'o555555555555;
    mem_read_ack  = 1'b1;
    @(posedge clk); #1;
    mem_read_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_ack", rd_ack_cnt - s, 0);
    mem_enable = 1'b1;
    s = mem_rd_starts;
    pag_req("rstmid_rd", 1'b0, 22'o3000, '0, K_READ, mem_value(22'o3000), 2 + mem_lat);
    check("rstmid_memrd", mem_rd_starts - s, 1);
    pag_req("rst_inval", 1'b0, 22'o1000, '0, K_READ, 36'o777, 2 + mem_lat);

    // Random mix on indices 8..11, two tags each, against a reference tag model.
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      a  = 22'o4010 + 22'($urandom_range(0, 3)) + 22'(64 * $urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      i6 = int'(a[5:0]);
      if (wr) begin
        d = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        pag_req("rnd_wr", 1'b1, a, d, K_WRITE, '0, 1 + mem_lat);
        check("rnd_wr_data", last_wdata, d);
      end else begin
        hit = ref_valid[i6] && (ref_tag[i6] == 16'(a >> 6));
        pag_req("rnd_rd", 1'b0, a, '0, K_READ, mem_value(a), hit ? 1 : 2 + mem_lat);
      end
      ref_valid[i6] = 1'b1;
      ref_tag[i6]   = 16'(a >> 6);
    end

`ifdef WT_CACHE_STATS_EN
    s  = int'(hit_count);
    hc = int'(miss_count);
    pag_req("st_miss", 1'b0, 22'o5000, '0, K_READ, mem_value(22'o5000), 2 + mem_lat);
    pag_req("st_hit1", 1'b0, 22'o5000, '0, K_READ, mem_value(22'o5000), 1);
    pag_req("st_hit2", 1'b0, 22'o5000, '0, K_READ, mem_value(22'o5000), 1);
    check("st_hits",   int'(hit_count) - s, 2);
    check("st_misses", int'(miss_count) - hc, 1);
`endif

    check("both_req", both_cnt, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
